// File: rtl/rng_hist_pkg.sv
// rng_hist_pkg: state type, default widths and bin-index helper shared by rng_hist.
package rng_hist_pkg;
  localparam int IN_WIDTH_D = 12;
  localparam int BIN_BITS_D = 6;
  localparam int CNT_WIDTH_D = 20;
  localparam int NS_WIDTH_D = 20;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;
  function automatic logic [31:0] bin_idx(input logic [31:0] d, input int in_w, input int bin_b);
    return d >> (in_w - bin_b);
  endfunction
endpackage

// File: rtl/rng_hist_if.sv
// rng_hist_if: sample stream and bin read port of rng_hist.
interface rng_hist_if
  import rng_hist_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_D,
  parameter int BIN_BITS = BIN_BITS_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D
);
  logic in_valid;
  logic [IN_WIDTH-1:0] in_data;
  logic rd_en;
  logic [BIN_BITS-1:0] rd_addr;
  logic [CNT_WIDTH-1:0] rd_data;
  logic rd_valid;
  modport master (output in_valid, in_data, rd_en, rd_addr, input rd_data, rd_valid);
  modport slave (input in_valid, in_data, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/rng_hist_ram.sv
// rng_hist_ram: simple dual-port bin RAM, one synchronous read port and one write port.
module rng_hist_ram #(
  parameter int AW = 6,
  parameter int DW = 20
) (
  input  logic clk,
  input  logic re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/rng_hist.sv
// rng_hist: clear-and-accumulate histogram of RNG samples with bin readout.
// RNG_HIST_SAT_EN: saturating bin counters and sticky sat flag; otherwise counters wrap.
module rng_hist
  import rng_hist_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_D,
  parameter int BIN_BITS = BIN_BITS_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D,
  parameter int NS_WIDTH = NS_WIDTH_D
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [NS_WIDTH-1:0] n_samps,
  rng_hist_if.slave bus,
  output logic busy,
  output logic done,
  output logic sat
);
  state_t state;
  logic [NS_WIDTH-1:0] ns, cnt;
  logic [BIN_BITS-1:0] clr, a_bin, b_bin, p_bin, wa, ra;
  logic [CNT_WIDTH-1:0] q, p_data, old, wd;
  logic b_vld, p_vld, acc, rd_fire, go, we, re, rv, open;
  assign open = state == IDLE || state == DONE;
  assign go = start && open;
  assign acc = state == ACCUM && bus.in_valid && cnt != ns;
  assign rd_fire = bus.rd_en && open && !start;
  assign a_bin = BIN_BITS'(bin_idx(32'(bus.in_data), IN_WIDTH, BIN_BITS));
  assign re = acc || rd_fire;
  assign ra = state == ACCUM ? a_bin : bus.rd_addr;
  assign we = state == CLEAR || b_vld;
  assign wa = state == CLEAR ? clr : b_bin;
  // previous-cycle write is not yet visible at the RAM read, so forward it
  assign old = (p_vld && p_bin == b_bin) ? p_data : q;
`ifdef RNG_HIST_SAT_EN
  logic full, sat_r;
  assign full = &old;
  assign wd = state == CLEAR ? '0 : full ? old : old + CNT_WIDTH'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) sat_r <= 1'b0;
    else if (go) sat_r <= 1'b0;
    else if (b_vld && full) sat_r <= 1'b1;
  assign sat = sat_r;
`else
  assign wd = state == CLEAR ? '0 : old + CNT_WIDTH'(1);
  assign sat = 1'b0;
`endif
  rng_hist_ram #(.AW(BIN_BITS), .DW(CNT_WIDTH)) u_ram (
    .clk(clk), .re(re), .ra(ra), .rd(q), .we(we), .wa(wa), .wd(wd)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ns <= '0;
      cnt <= '0;
      clr <= '0;
      b_vld <= 1'b0;
      b_bin <= '0;
      p_vld <= 1'b0;
      p_bin <= '0;
      p_data <= '0;
      rv <= 1'b0;
    end else begin
      rv <= rd_fire;
      b_vld <= acc;
      b_bin <= a_bin;
      p_vld <= we;
      p_bin <= wa;
      p_data <= wd;
      if (acc) cnt <= cnt + NS_WIDTH'(1);
      if (state == CLEAR) clr <= clr + BIN_BITS'(1);
      if (go) begin
        state <= CLEAR;
        ns <= n_samps;
        cnt <= '0;
        clr <= '0;
      end else if (state == CLEAR && &clr) state <= ns == '0 ? DONE : ACCUM;
      else if (state == ACCUM && b_vld && cnt == ns) state <= DONE;
    end
  assign busy = state == CLEAR || state == ACCUM;
  assign done = state == DONE;
  assign bus.rd_valid = rv;
  assign bus.rd_data = rv ? q : '0;
endmodule

// File: tb/tb_rng_hist.sv
// tb_rng_hist: scoreboard bench for rng_hist; a 20-bit and a 4-bit-counter instance share stimulus.
module tb_rng_hist;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, rd_en = 1'b0;
  logic [19:0] n_samps = '0;
  logic [11:0] in_data = '0;
  logic [5:0] rd_addr = '0;
  logic busy_w, done_w, sat_w, busy_n, done_n, sat_n;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  rng_hist_if #(.CNT_WIDTH(20)) bw();
  rng_hist_if #(.CNT_WIDTH(4)) bn();
  assign bw.in_valid = in_valid;
  assign bw.in_data = in_data;
  assign bw.rd_en = rd_en;
  assign bw.rd_addr = rd_addr;
  assign bn.in_valid = in_valid;
  assign bn.in_data = in_data;
  assign bn.rd_en = rd_en;
  assign bn.rd_addr = rd_addr;
  rng_hist u_w (.clk(clk), .rst(rst), .start(start), .n_samps(n_samps), .bus(bw),
                .busy(busy_w), .done(done_w), .sat(sat_w));
  rng_hist #(.CNT_WIDTH(4)) u_n (.clk(clk), .rst(rst), .start(start), .n_samps(n_samps), .bus(bn),
                                 .busy(busy_n), .done(done_n), .sat(sat_n));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // reference model: run window, accept rule and bin contents from the block's rules
  typedef struct { int w; int n; } exp_t;
  exp_t q[$];
  int hw[64], hn[64];
  bit run, dn, smod, spend;
  int pc = 0, p0, need, got, done_at, b;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      run = 0; dn = 0; smod = 0; spend = 0;
      q.delete();
    end else begin
      pc++;
      smod = smod | spend;
      spend = 0;
      if (rd_en && !run && !start) q.push_back('{w: hw[rd_addr], n: hn[rd_addr]});
      if (start && !run) begin
        run = 1; dn = 0; smod = 0; p0 = pc; need = int'(n_samps); got = 0;
        done_at = need == 0 ? pc + 64 : -1;
        foreach (hw[i]) begin hw[i] = 0; hn[i] = 0; end
      end else if (run) begin
        if (pc >= p0 + 65 && in_valid && got < need) begin
          b = int'(in_data) / 64;
          hw[b]++;
`ifdef RNG_HIST_SAT_EN
          if (hn[b] == 15) spend = 1; else hn[b]++;
`else
          hn[b] = (hn[b] + 1) % 16;
`endif
          got++;
          if (got == need) done_at = pc + 1;
        end
        if (pc == done_at) begin run = 0; dn = 1; end
      end
    end
  always @(negedge clk) begin
    exp_t e;
    chk("busy_w", busy_w, run);
    chk("done_w", done_w, dn);
    chk("sat_w", sat_w, 0);
    chk("busy_n", busy_n, run);
    chk("done_n", done_n, dn);
`ifdef RNG_HIST_SAT_EN
    chk("sat_n", sat_n, smod);
`else
    chk("sat_n", sat_n, 0);
`endif
    chk("rd_valid_w", bw.rd_valid, q.size() != 0);
    chk("rd_valid_n", bn.rd_valid, q.size() != 0);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rd_data_w", bw.rd_data, e.w);
      chk("rd_data_n", bn.rd_data, e.n);
    end
  end
  task automatic tick; @(posedge clk); #1; endtask
  task automatic idle_in; in_valid = 0; rd_en = 0; start = 0; endtask
  task automatic chk_reset;
    chk("rst_busy_w", busy_w, 0); chk("rst_done_w", done_w, 0); chk("rst_sat_w", sat_w, 0);
    chk("rst_rdv_w", bw.rd_valid, 0); chk("rst_rdd_w", bw.rd_data, 0);
    chk("rst_busy_n", busy_n, 0); chk("rst_done_n", done_n, 0); chk("rst_sat_n", sat_n, 0);
    chk("rst_rdv_n", bn.rd_valid, 0); chk("rst_rdd_n", bn.rd_data, 0);
  endtask
  // start pulse then 64 clear cycles of junk that must all be ignored
  task automatic kick(input int n, input bit with_rd);
    start = 1; n_samps = 20'(n); rd_en = with_rd; rd_addr = 6'($urandom);
    tick;
    repeat (64) begin
      in_valid = 1'($urandom); in_data = 12'($urandom); rd_en = 1'($urandom);
      rd_addr = 6'($urandom); start = $urandom_range(0, 7) == 0; n_samps = 20'($urandom);
      tick;
    end
    idle_in;
  endtask
  task automatic feed(input logic v, input logic [11:0] d);
    in_valid = v; in_data = d; tick;
  endtask
  task automatic finish_run(input bit rnd);
    int k = 0;
    while (!dn && k < 3000) begin
      in_valid = rnd ? 1'($urandom) : 1'b0; in_data = 12'($urandom);
      tick; k++;
    end
    idle_in;
    chk("run_done", done_w, 1);
  endtask
  task automatic read_all;
    for (int a = 0; a < 64; a++) begin rd_en = 1; rd_addr = 6'(a); tick; end
    rd_en = 0; tick; tick;
  endtask
  initial begin
    repeat (3) tick;
    chk_reset;
    rst = 1; tick;
    kick(0, 0); finish_run(0); read_all;
    kick(4, 1);
    feed(1, 12'h000); feed(1, 12'h03F); feed(1, 12'h040); feed(1, 12'hFFF);
    finish_run(0); read_all;
    kick(1000, 0);
    repeat (1000) feed(1, 12'h800);
    finish_run(0); read_all;
    kick(4, 0);
    rd_en = 1; rd_addr = 6'd5;
    feed(1, 12'h140); feed(1, 12'h140); feed(0, 12'h000); feed(1, 12'h180);
    feed(0, 12'h140); feed(0, 12'h000); feed(1, 12'h140); feed(1, 12'h140); feed(1, 12'h180);
    finish_run(0); read_all;
    kick(20, 0);
    repeat (20) feed(1, 12'h0C0);
    finish_run(0); read_all;
    repeat (6) begin
      kick($urandom_range(1, 150), 0); finish_run(1); read_all;
    end
    kick(50, 0);
    repeat (10) feed(1, 12'($urandom));
    rst = 0; idle_in; tick;
    chk_reset;
    tick; rst = 1; tick;
    kick(2, 0); feed(1, 12'h7FF); feed(1, 12'h7C0);
    finish_run(0); read_all;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rng_hist.md
# rng_hist

On-chip histogram accumulator that consumes the sample stream of the CLT Gaussian RNG (`TOP_RNG` / `CLT_RNG` outputs) and bins it into RAM. It replaces the off-line dump-and-histogram flow with a hardware check of the RNG distribution. It clears its bins, accumulates a programmed number of samples, then exposes the bin counts through a synchronous read port for a host or bench to fetch.

## Interface

Parameters:
- `IN_WIDTH`, 12, RNG sample width. Samples are unsigned offset code.
- `BIN_BITS`, 6, log2 of the bin count. The bin index is `in_data[IN_WIDTH-1 -: BIN_BITS]`.
- `CNT_WIDTH`, 20, width of each bin counter.
- `NS_WIDTH`, 20, width of the sample-count target.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse. Begins a clear-and-accumulate run.
- `n_samps`  in  NS_WIDTH  samples to accumulate. Sampled when `start` is accepted.
- `in_valid`  in  1  sample qualifier.
- `in_data`  in  IN_WIDTH  RNG sample.
- `rd_en`  in  1  bin read request.
- `rd_addr`  in  BIN_BITS  bin to read.
- `rd_data`  out  CNT_WIDTH  bin count.
- `rd_valid`  out  1  `rd_data` valid.
- `busy`  out  1  high in CLEAR and ACCUM.
- `done`  out  1  high in DONE.
- `sat`  out  1  sticky: some bin saturated this run.

## Operation

- FSM states are IDLE, CLEAR, ACCUM, DONE.
- Reset: state is IDLE. `rd_data`, `rd_valid`, `busy`, `done` and `sat` are all 0. RAM contents are undefined until the first CLEAR.
- IDLE/DONE + `start` → CLEAR. Latch `n_samps`, clear `sat` and the sample counter. `start` in CLEAR or ACCUM is ignored.
- CLEAR writes 0 to bins 0..2^BIN_BITS-1, one per cycle, then moves to ACCUM. If the latched `n_samps` is 0, it moves straight to DONE. `in_valid` is ignored during CLEAR.
- ACCUM accepts a sample on every `in_valid` cycle until the accepted count equals `n_samps`. Further `in_valid` is ignored.
- Read-modify-write pipeline:
  - Stage A (acceptance cycle): register the bin and issue the RAM read.
  - Stage B (next cycle): increment and write.
  - Hazard: if the stage-B bin equals the bin written in the previous cycle, use the forwarded write value instead of the RAM output. Back-to-back same-bin samples must count exactly.
- After the last write: ACCUM → DONE.
- Readout: the read port is shared with stage A and is serviced in IDLE and DONE only. `rd_en` in CLEAR or ACCUM is ignored and `rd_valid` stays 0.
- Counter width: `CNT_WIDTH`. Sample counter width: `NS_WIDTH`.

## Timing

- `start` at cycle t → `busy`=1 from t+1. CLEAR occupies 2^BIN_BITS cycles.
- Last sample accepted at cycle k → written at k+1 → `done`=1 and `busy`=0 from k+2.
- `rd_en` at cycle r → `rd_valid`=1 and `rd_data` valid at r+1. One read per cycle, fully pipelined.
- `rst` asserted in any state → immediate IDLE with reset output values. The partial histogram is discarded (treated as undefined).
- `start` coincident with `rd_en` in DONE: `start` wins and the read is dropped.

## Configuration

- `RNG_HIST_SAT_EN` defined: bin counters saturate at 2^CNT_WIDTH-1, and `sat` is set (sticky until the next `start`) when an increment is blocked.
- `RNG_HIST_SAT_EN` undefined: counters wrap modulo 2^CNT_WIDTH and `sat` is tied to 0.

## Structure

- Package `rng_hist_pkg` holds:
  - the state enum typedef;
  - default width constants (IN_WIDTH=12, matching the RNG `OUT_WIDTH`);
  - the bin-index extraction function.
- Sub-module `rng_hist_ram`: simple dual-port RAM, one synchronous-read port and one write port, 2^BIN_BITS × CNT_WIDTH, no reset.

## Test plan

- Reset, then `start` with n_samps=0 → `busy` for 64 cycles, `done`=1; all 64 bins read 0 with `rd_valid` one cycle after each `rd_en`.
- n_samps=4 with samples 0x000, 0x03F, 0x040, 0xFFF → bin0=2, bin1=1, bin63=1, all others 0.
- n_samps=1000 with 0x800 on every cycle (back-to-back) → bin32=1000, and `done` rises 2 cycles after the 1000th accept.
- n_samps=4 with gapped `in_valid` and bins 5,5,6,5 (with and without bubbles between equal bins) → bin5=3, bin6=1; extra valids after the 4th are ignored.
- CNT_WIDTH=4, n_samps=20, all samples bin 3 → with `RNG_HIST_SAT_EN`: bin3=15, `sat`=1; without: bin3=4, `sat`=0.
- `rst` low mid-ACCUM → outputs 0 and state IDLE; a following `start` with n_samps=2 gives a clean two-count histogram.
